// File: rtl/alu_stage_ctrl_pkg.sv
// rtl/alu_stage_ctrl_pkg.sv - shared encodings for the ALU stage control FSM
package alu_stage_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IFETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_B     = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef enum logic [1:0] {
    IMM_SEXT     = 2'b00,
    IMM_ZEXT     = 2'b01,
    IMM_HI16     = 2'b10,
    IMM_SEXT_SH2 = 2'b11
  } imm_ext_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL,
    CL_RTYPE,
    CL_IMM,
    CL_LOAD,
    CL_STORE,
    CL_BEQ,
    CL_BNE,
    CL_JUMP
  } iclass_t;

  typedef struct packed {
    iclass_t    iclass;
    logic [3:0] alu_func;
    imm_ext_t   imm_ext;
  } dec_t;

endpackage

// File: rtl/alu_stage_ctrl_decode.sv
// rtl/alu_stage_ctrl_decode.sv - opcode/func to instruction class, ALU op and immediate mode
module alu_stage_ctrl_decode
  import alu_stage_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [3:0] func,
  output dec_t       dec
);

  always_comb begin
    dec.iclass   = CL_ILLEGAL;
    dec.alu_func = ALU_ADD;
    dec.imm_ext  = IMM_SEXT;
    case (opcode)
      OP_RTYPE: begin
        dec.iclass   = CL_RTYPE;
        dec.alu_func = func;
      end
      OP_ADDI: dec.iclass = CL_IMM;
      OP_ANDI: begin
        dec.iclass   = CL_IMM;
        dec.alu_func = ALU_AND;
        dec.imm_ext  = IMM_ZEXT;
      end
      OP_ORI: begin
        dec.iclass   = CL_IMM;
        dec.alu_func = ALU_OR;
        dec.imm_ext  = IMM_ZEXT;
      end
      // li relies on the datapath reading R0 as RF_A, so it is just an OR with R0
      OP_LI: begin
        dec.iclass   = CL_IMM;
        dec.alu_func = ALU_OR;
      end
      OP_LW: dec.iclass = CL_LOAD;
      OP_SW: dec.iclass = CL_STORE;
      OP_BEQ: begin
        dec.iclass   = CL_BEQ;
        dec.alu_func = ALU_SUB;
        dec.imm_ext  = IMM_SEXT_SH2;
      end
      OP_BNE: begin
        dec.iclass   = CL_BNE;
        dec.alu_func = ALU_SUB;
        dec.imm_ext  = IMM_SEXT_SH2;
      end
      OP_B: begin
        dec.iclass  = CL_JUMP;
        dec.imm_ext = IMM_SEXT_SH2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_stage_ctrl.sv
// rtl/alu_stage_ctrl.sv - multi-cycle control FSM sequencing fetch, decode, execute, memory and writeback
module alu_stage_ctrl
  import alu_stage_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  input  logic        Mem_ready,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic [1:0]  ImmExt,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_req,
  output logic        MEM_WrEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        Illegal
);

  state_t     state;
  logic       rst_hold;
  logic [5:0] op_q;
  logic [3:0] func_q;
  logic [5:0] dec_op;
  logic [3:0] dec_func;
  dec_t       dec;
  logic       unused_instr;

  assign unused_instr = ^Instr[25:4];

  // In DECODE the captured copy is still stale, so decode straight from the IR
  assign dec_op   = (state == ST_DECODE) ? Instr[31:26] : op_q;
  assign dec_func = (state == ST_DECODE) ? Instr[3:0]   : func_q;

  alu_stage_ctrl_decode u_decode (
    .opcode (dec_op),
    .func   (dec_func),
    .dec    (dec)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= ST_IFETCH;
      rst_hold <= 1'b1;
      op_q     <= '0;
      func_q   <= '0;
    end else if (rst_hold) begin
      // One blanked cycle after reset so IFETCH only starts once Reset is high
      rst_hold <= 1'b0;
      state    <= ST_IFETCH;
    end else begin
      case (state)
        ST_IFETCH: state <= ST_DECODE;
        ST_DECODE: begin
          op_q   <= Instr[31:26];
          func_q <= Instr[3:0];
          state  <= (dec.iclass == CL_ILLEGAL) ? ST_IFETCH : ST_EXEC;
        end
        ST_EXEC: begin
          case (dec.iclass)
            CL_RTYPE, CL_IMM:  state <= ST_WB;
            CL_LOAD, CL_STORE: state <= ST_MEM;
            default:           state <= ST_IFETCH;
          endcase
        end
        ST_MEM: begin
          if (Mem_ready) state <= (dec.iclass == CL_LOAD) ? ST_WB : ST_IFETCH;
        end
        ST_WB:   state <= ST_IFETCH;
        default: state <= ST_IFETCH;
      endcase
    end
  end

  always_comb begin
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    ImmExt        = IMM_SEXT;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    Mem_req       = 1'b0;
    MEM_WrEn      = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    Illegal       = 1'b0;
    if (!rst_hold) begin
      case (state)
        ST_IFETCH: IR_LdEn = 1'b1;
        ST_DECODE: begin
          if (dec.iclass == CL_ILLEGAL) begin
            Illegal = 1'b1;
            PC_LdEn = 1'b1;
          end
        end
        ST_EXEC: begin
          ALU_func = dec.alu_func;
          ImmExt   = dec.imm_ext;
          case (dec.iclass)
            CL_IMM, CL_LOAD, CL_STORE: ALU_Bin_sel = 1'b1;
            CL_BEQ: begin
              RF_B_sel = 1'b1;
              PC_LdEn  = 1'b1;
              PC_sel   = ALU_zero;
            end
            CL_BNE: begin
              RF_B_sel = 1'b1;
              PC_LdEn  = 1'b1;
              PC_sel   = !ALU_zero;
            end
            CL_JUMP: begin
              PC_LdEn = 1'b1;
              PC_sel  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          Mem_req = 1'b1;
          if (dec.iclass == CL_STORE) begin
            MEM_WrEn = 1'b1;
            RF_B_sel = 1'b1;
            PC_LdEn  = Mem_ready;
          end
        end
        ST_WB: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = (dec.iclass == CL_LOAD);
          PC_LdEn       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stage_ctrl.sv
// tb/tb_alu_stage_ctrl.sv - randomized self-checking bench for alu_stage_ctrl
module tb_alu_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Instr = '0;
  logic        ALU_zero = 1'b0;
  logic        Mem_ready = 1'b0;
  logic        IR_LdEn, PC_LdEn, PC_sel, RF_B_sel, ALU_Bin_sel;
  logic [1:0]  ImmExt;
  logic [3:0]  ALU_func;
  logic        Mem_req, MEM_WrEn, RF_WrEn, RF_WrData_sel, Illegal;
  logic [15:0] obs_vec;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic        rdy_q[$];
  logic        zr_q[$];

  alu_stage_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instr         (Instr),
    .ALU_zero      (ALU_zero),
    .Mem_ready     (Mem_ready),
    .IR_LdEn       (IR_LdEn),
    .PC_LdEn       (PC_LdEn),
    .PC_sel        (PC_sel),
    .ImmExt        (ImmExt),
    .RF_B_sel      (RF_B_sel),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .ALU_func      (ALU_func),
    .Mem_req       (Mem_req),
    .MEM_WrEn      (MEM_WrEn),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .Illegal       (Illegal)
  );

  always #5 Clk = ~Clk;

  assign obs_vec = {IR_LdEn, PC_LdEn, PC_sel, ImmExt, RF_B_sel, ALU_Bin_sel, ALU_func,
                    Mem_req, MEM_WrEn, RF_WrEn, RF_WrData_sel, Illegal};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mk(input logic ir, input logic pcl, input logic pcs,
                                     input logic [1:0] imm, input logic rfb, input logic bin,
                                     input logic [3:0] alu, input logic mreq, input logic mwr,
                                     input logic rfw, input logic rfd, input logic ill);
    return {ir, pcl, pcs, imm, rfb, bin, alu, mreq, mwr, rfw, rfd, ill};
  endfunction

  task automatic push(input logic [15:0] v, input logic rdy, input logic zr);
    exp_q.push_back(v);
    rdy_q.push_back(rdy);
    zr_q.push_back(zr);
  endtask

  // Expected per-cycle trace of one instruction, straight from the instruction table
  task automatic build(input logic [5:0] op, input logic [3:0] fn, input logic z, input int nwait);
    logic [15:0] wb_alu, wb_ld;
    exp_q.delete(); rdy_q.delete(); zr_q.delete();
    wb_alu = mk(0, 1, 0, 2'b00, 0, 0, 4'h0, 0, 0, 1, 0, 0);
    wb_ld  = mk(0, 1, 0, 2'b00, 0, 0, 4'h0, 0, 0, 1, 1, 0);
    push(mk(1, 0, 0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom));
    case (op)
      6'b100000, 6'b110000, 6'b110010, 6'b110011, 6'b111000, 6'b001111, 6'b011111,
      6'b000000, 6'b000001, 6'b111111:
        push(16'h0000, 1'($urandom), 1'($urandom));
      default: begin
        push(mk(0, 1, 0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 0, 1), 1'($urandom), 1'($urandom));
        return;
      end
    endcase
    case (op)
      6'b100000: begin
        push(mk(0, 0, 0, 2'b00, 0, 0, fn, 0, 0, 0, 0, 0), 1'($urandom), z);
        push(wb_alu, 1'($urandom), 1'($urandom));
      end
      6'b110000, 6'b110010, 6'b110011, 6'b111000: begin
        case (op)
          6'b110000: push(mk(0, 0, 0, 2'b00, 0, 1, 4'h0, 0, 0, 0, 0, 0), 1'($urandom), z);
          6'b110010: push(mk(0, 0, 0, 2'b01, 0, 1, 4'h2, 0, 0, 0, 0, 0), 1'($urandom), z);
          6'b110011: push(mk(0, 0, 0, 2'b01, 0, 1, 4'h3, 0, 0, 0, 0, 0), 1'($urandom), z);
          default:   push(mk(0, 0, 0, 2'b00, 0, 1, 4'h3, 0, 0, 0, 0, 0), 1'($urandom), z);
        endcase
        push(wb_alu, 1'($urandom), 1'($urandom));
      end
      6'b001111, 6'b011111: begin
        logic st;
        st = (op == 6'b011111);
        push(mk(0, 0, 0, 2'b00, 0, 1, 4'h0, 0, 0, 0, 0, 0), 1'($urandom), z);
        for (int k = 0; k <= nwait; k++)
          push(mk(0, st && (k == nwait), 0, 2'b00, st, 0, 4'h0, 1, st, 0, 0, 0),
               (k == nwait), 1'($urandom));
        if (!st) push(wb_ld, 1'($urandom), 1'($urandom));
      end
      6'b000000: push(mk(0, 1, z, 2'b11, 1, 0, 4'h1, 0, 0, 0, 0, 0), 1'($urandom), z);
      6'b000001: push(mk(0, 1, !z, 2'b11, 1, 0, 4'h1, 0, 0, 0, 0, 0), 1'($urandom), z);
      default:   push(mk(0, 1, 1, 2'b11, 0, 0, 4'h0, 0, 0, 0, 0, 0), 1'($urandom), z);
    endcase
  endtask

  task automatic tick(input logic rst, input logic rdy, input logic zr, input logic [31:0] ins);
    @(posedge Clk);
    #1;
    Reset = rst; Mem_ready = rdy; ALU_zero = zr; Instr = ins;
    @(negedge Clk);
  endtask

  // abort_at: cycle (1-based) in which Reset is pulled low, 0 for none
  task automatic run(input string tag, input logic [31:0] ins, input logic z,
                     input int nwait, input int abort_at);
    int pcl;
    pcl = 0;
    build(ins[31:26], ins[3:0], z, nwait);
    for (int c = 0; c < exp_q.size(); c++) begin
      if (abort_at != 0 && c >= abort_at) break;
      tick(!(c + 1 == abort_at), rdy_q[c], zr_q[c], ins);
      check($sformatf("%s c%0d", tag, c + 1), obs_vec, exp_q[c]);
      if (PC_LdEn) pcl++;
    end
    if (abort_at != 0) begin
      tick(1'b1, 1'b0, 1'($urandom), ins);
      check($sformatf("%s abort", tag), obs_vec, 16'h0000);
      check($sformatf("%s pc_cnt", tag), 16'(pcl), 16'd0);
    end else begin
      check($sformatf("%s pc_cnt", tag), 16'(pcl), 16'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  ops[10];
    logic [31:0] ins;
    int          sel;
    ops = '{6'b100000, 6'b110000, 6'b110010, 6'b110011, 6'b111000,
            6'b001111, 6'b011111, 6'b000000, 6'b000001, 6'b111111};

    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'($urandom), 1'($urandom), $urandom);
      check($sformatf("reset%0d", i), obs_vec, 16'h0000);
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("reset_release", obs_vec, 16'h0000);

    run("add", 32'h8000_0030, 1'b0, 0, 0);
    run("beq_z1", 32'h0000_1234, 1'b1, 0, 0);
    run("beq_z0", 32'h0000_1234, 1'b0, 0, 0);
    run("bne_z1", 32'h0400_0010, 1'b1, 0, 0);
    run("lw_w3", 32'h3C00_0004, 1'b0, 3, 0);
    run("sw_w0", 32'h7C00_0008, 1'b0, 0, 0);
    run("sw_abort", 32'h7C00_0008, 1'b0, 5, 5);
    run("illegal", 32'hA800_0000, 1'b0, 0, 0);
    run("b", 32'hFC00_0100, 1'b0, 0, 0);
    run("li", 32'hE000_00FF, 1'b1, 0, 0);

    for (int n = 0; n < 150; n++) begin
      ins = $urandom;
      sel = $urandom_range(0, 11);
      if (sel < 10) ins[31:26] = ops[sel];
      run($sformatf("rnd%0d", n), ins, 1'($urandom), $urandom_range(0, 4), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
